// File: rtl/scaler_core.sv
// Start/done power-of-two image scaler: reads a source image one pixel at a time
// from a synchronous ROM and writes the scaled result, centred, into the frame buffer.
module scaler_core #(
    parameter int unsigned SRC_W     = 160,
    parameter int unsigned SRC_H     = 120,
    parameter int unsigned DST_W     = 640,
    parameter int unsigned DST_H     = 480,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned MAX_SHIFT = 2,
    parameter int unsigned SRC_AW    = 15,
    parameter int unsigned DST_AW    = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [1:0]        shift,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [PIX_W-1:0]  src_data,
    output logic [DST_AW-1:0] dst_addr,
    output logic [PIX_W-1:0]  dst_data,
    output logic              dst_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CW = $clog2(((SRC_W > DST_W) ? SRC_W : DST_W) + 1);
    localparam int unsigned BW = MAX_SHIFT + 1;
    localparam int unsigned AW = PIX_W + 2 * MAX_SHIFT;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_ACCUM, S_WRITE, S_DONE} state_t;
    typedef enum logic [1:0] {M_REP = 2'd0, M_DEC = 2'd1, M_AVG = 2'd2, M_PASS = 2'd3} mode_t;

    state_t          state;
    mode_t           mode_r;
    logic [1:0]      shift_r;
    logic [CW-1:0]   out_w, out_h, off_x, off_y, ox, oy;
    logic [BW-1:0]   bx, by;
    logic [AW-1:0]   acc;

    logic [1:0]      req_shift;
    int unsigned     req_w, req_h;
    logic            req_ok;

    // Request decode: effective shift, output size and legality of a new job
    always_comb begin
        req_shift = (mode == 2'b11) ? 2'd0 : shift;
        case (mode)
            2'b00: begin
                req_w = SRC_W << req_shift;
                req_h = SRC_H << req_shift;
            end
            2'b11: begin
                req_w = SRC_W;
                req_h = SRC_H;
            end
            default: begin
                req_w = SRC_W >> req_shift;
                req_h = SRC_H >> req_shift;
            end
        endcase
        req_ok = (32'(req_shift) <= MAX_SHIFT) && (req_w <= DST_W) && (req_h <= DST_H);
    end

    logic [BW-1:0]   blk_max, nbx, nby;
    logic            blk_last, pix_last, row_end;
    logic [CW-1:0]   nox, noy;
    logic [AW-1:0]   acc_sum;
    logic [2:0]      div_sh;

    // Block and pixel stepping; the block is a single sample outside average mode
    always_comb begin
        blk_max  = BW'((32'd1 << shift_r) - 32'd1);
        blk_last = (mode_r != M_AVG) || ((bx == blk_max) && (by == blk_max));
        nbx      = (bx == blk_max) ? '0 : bx + BW'(1);
        nby      = (bx == blk_max) ? by + BW'(1) : by;
        row_end  = (ox == out_w - CW'(1));
        pix_last = row_end && (oy == out_h - CW'(1));
        nox      = row_end ? '0 : ox + CW'(1);
        noy      = row_end ? oy + CW'(1) : oy;
        acc_sum  = acc + AW'(src_data);
        div_sh   = (mode_r == M_AVG) ? {shift_r, 1'b0} : 3'd0;
    end

    function automatic logic [SRC_AW-1:0] src_index(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                                    input logic [BW-1:0] dx, input logic [BW-1:0] dy);
        int unsigned sx, sy;
        case (mode_r)
            M_REP: begin
                sx = 32'(x) >> shift_r;
                sy = 32'(y) >> shift_r;
            end
            M_PASS: begin
                sx = 32'(x);
                sy = 32'(y);
            end
            default: begin
                sx = (32'(x) << shift_r) + 32'(dx);
                sy = (32'(y) << shift_r) + 32'(dy);
            end
        endcase
        return SRC_AW'(sy * SRC_W + sx);
    endfunction

    function automatic logic [DST_AW-1:0] dst_index(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return DST_AW'((32'(off_y) + 32'(y)) * DST_W + 32'(off_x) + 32'(x));
    endfunction

    // Control FSM with registered outputs; abort overrides every transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mode_r   <= M_REP;
            shift_r  <= 2'd0;
            out_w    <= '0;
            out_h    <= '0;
            off_x    <= '0;
            off_y    <= '0;
            ox       <= '0;
            oy       <= '0;
            bx       <= '0;
            by       <= '0;
            acc      <= '0;
            src_addr <= '0;
            dst_addr <= '0;
            dst_data <= '0;
            dst_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            dst_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (req_ok) begin
                                state    <= S_READ;
                                busy     <= 1'b1;
                                mode_r   <= mode_t'(mode);
                                shift_r  <= req_shift;
                                out_w    <= CW'(req_w);
                                out_h    <= CW'(req_h);
                                off_x    <= CW'((DST_W - req_w) >> 1);
                                off_y    <= CW'((DST_H - req_h) >> 1);
                                ox       <= '0;
                                oy       <= '0;
                                bx       <= '0;
                                by       <= '0;
                                acc      <= '0;
                                src_addr <= '0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    S_READ: state <= S_ACCUM;
                    S_ACCUM: begin
                        acc <= acc_sum;
                        if (!blk_last) begin
                            bx       <= nbx;
                            by       <= nby;
                            src_addr <= src_index(ox, oy, nbx, nby);
                            state    <= S_READ;
                        end else begin
                            dst_addr <= dst_index(ox, oy);
                            dst_data <= PIX_W'(acc_sum >> div_sh);
                            dst_we   <= 1'b1;
                            state    <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        acc <= '0;
                        bx  <= '0;
                        by  <= '0;
                        if (pix_last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            ox       <= nox;
                            oy       <= noy;
                            src_addr <= src_index(nox, noy, '0, '0);
                            state    <= S_READ;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scaler_core.sv
// Randomised self-checking bench for scaler_core against a plain-arithmetic model.
module tb_scaler_core;

    localparam int unsigned SW = 4, SH = 4, DW = 16, DH = 16, PW = 8, MS = 2, SAW = 4, DAW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, start, start_n, abort;
    logic [1:0]     mode, shift;
    logic [SAW-1:0] src_addr, src_addr_n;
    logic [PW-1:0]  src_data, src_data_n;
    logic [DAW-1:0] dst_addr, dst_addr_n;
    logic [PW-1:0]  dst_data, dst_data_n;
    logic           dst_we, busy, done, err;
    logic           dst_we_n, busy_n, done_n, err_n;

    logic [PW-1:0]  rom [16];

    scaler_core #(.SRC_W(SW), .SRC_H(SH), .DST_W(DW), .DST_H(DH), .PIX_W(PW),
                  .MAX_SHIFT(MS), .SRC_AW(SAW), .DST_AW(DAW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode), .shift(shift),
        .src_addr(src_addr), .src_data(src_data), .dst_addr(dst_addr), .dst_data(dst_data),
        .dst_we(dst_we), .busy(busy), .done(done), .err(err));

    // Narrow frame buffer instance for the width-overflow rejection case
    scaler_core #(.SRC_W(SW), .SRC_H(SH), .DST_W(8), .DST_H(DH), .PIX_W(PW),
                  .MAX_SHIFT(MS), .SRC_AW(SAW), .DST_AW(DAW)) dut_n (
        .clk(clk), .reset(reset), .start(start_n), .abort(abort), .mode(mode), .shift(shift),
        .src_addr(src_addr_n), .src_data(src_data_n), .dst_addr(dst_addr_n), .dst_data(dst_data_n),
        .dst_we(dst_we_n), .busy(busy_n), .done(done_n), .err(err_n));

    always @(posedge clk) begin
        src_data   <= rom[src_addr];
        src_data_n <= rom[src_addr_n];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int exp_addr[$];
    int exp_data[$];
    int exp_ok, exp_cyc, exp_cost;

    // Reference: walk the output window and derive each pixel from the source image
    task automatic build_model(input int m, input int s_in);
        int s, nb, ow, oh, offx, offy, v, sum;
        s  = (m == 3) ? 0 : s_in;
        nb = 1;
        for (int i = 0; i < s; i++) nb = nb * 2;
        if (m == 0)      begin ow = SW * nb; oh = SH * nb; end
        else if (m == 3) begin ow = SW;      oh = SH;      end
        else             begin ow = SW / nb; oh = SH / nb; end
        exp_addr.delete();
        exp_data.delete();
        exp_ok   = (s <= MS) && (ow <= DW) && (oh <= DH);
        exp_cost = (m == 2) ? 2 * nb * nb + 1 : 3;
        exp_cyc  = 1 + ow * oh * exp_cost + 1;
        if (exp_ok) begin
            offx = (DW - ow) / 2;
            offy = (DH - oh) / 2;
            for (int y = 0; y < oh; y++) begin
                for (int x = 0; x < ow; x++) begin
                    case (m)
                        0: v = int'(rom[(y / nb) * SW + x / nb]);
                        1: v = int'(rom[(y * nb) * SW + x * nb]);
                        2: begin
                            sum = 0;
                            for (int by = 0; by < nb; by++)
                                for (int bx = 0; bx < nb; bx++)
                                    sum += int'(rom[(y * nb + by) * SW + x * nb + bx]);
                            v = sum / (nb * nb);
                        end
                        default: v = int'(rom[y * SW + x]);
                    endcase
                    exp_addr.push_back((offy + y) * DW + offx + x);
                    exp_data.push_back(v);
                end
            end
        end
    endtask

    task automatic run_job(input int m, input int s, input string tag);
        int cyc, limit, n_err, n_done, done_cyc, busy_seen, b2b, last_we;
        int got_a[$];
        int got_d[$];
        int got_c[$];
        build_model(m, s);
        limit = exp_ok ? exp_cyc + 50 : 10;
        n_err = 0; n_done = 0; done_cyc = 0; busy_seen = 0; b2b = 0; last_we = -10;
        @(negedge clk);
        mode  = 2'(m);
        shift = 2'(s);
        start = 1'b1;
        cyc   = 1;
        while (cyc < limit) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (dst_we) begin
                if (cyc == last_we + 1) b2b++;
                last_we = cyc;
                got_a.push_back(int'(dst_addr));
                got_d.push_back(int'(dst_data));
                got_c.push_back(cyc);
            end
            if (err)  n_err++;
            if (busy) busy_seen++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
                break;
            end
        end
        if (exp_ok) begin
            check({tag, " err"}, 32'(n_err), 32'd0);
            check({tag, " done cycle"}, 32'(done_cyc), 32'(exp_cyc));
            check({tag, " busy at done"}, 32'(busy), 32'd1);
            @(negedge clk);
            check({tag, " busy after"}, 32'(busy), 32'd0);
            check({tag, " writes"}, 32'(got_a.size()), 32'(exp_addr.size()));
            for (int i = 0; i < got_a.size() && i < exp_addr.size(); i++) begin
                check({tag, " addr"}, 32'(got_a[i]), 32'(exp_addr[i]));
                check({tag, " data"}, 32'(got_d[i]), 32'(exp_data[i]));
                if (i > 0) check({tag, " pixel cycles"}, 32'(got_c[i] - got_c[i-1]), 32'(exp_cost));
            end
            check({tag, " back-to-back we"}, 32'(b2b), 32'd0);
        end else begin
            check({tag, " err pulses"}, 32'(n_err), 32'd1);
            check({tag, " writes"}, 32'(got_a.size()), 32'd0);
            check({tag, " busy seen"}, 32'(busy_seen), 32'd0);
            check({tag, " done"}, 32'(n_done), 32'd0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " src_addr"}, 32'(src_addr), 32'd0);
        check({tag, " dst_addr"}, 32'(dst_addr), 32'd0);
        check({tag, " dst_data"}, 32'(dst_data), 32'd0);
        check({tag, " dst_we"}, 32'(dst_we), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int cyc, n_done, n_we;
        reset = 1'b1; start = 1'b0; start_n = 1'b0; abort = 1'b0; mode = 2'd0; shift = 2'd0;
        for (int i = 0; i < 16; i++) rom[i] = PW'(i);
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        run_job(0, 1, "rep s1");
        run_job(2, 1, "avg s1");
        run_job(1, 2, "dec s2");
        run_job(0, 3, "rep s3 illegal");

        // Replicate x4 overflows an 8-pixel-wide frame buffer
        @(negedge clk);
        mode = 2'd0; shift = 2'd2; start_n = 1'b1;
        @(negedge clk);
        start_n = 1'b0;
        check("narrow err", 32'(err_n), 32'd1);
        n_we = 0;
        for (int i = 0; i < 6; i++) begin
            if (dst_we_n || busy_n) n_we++;
            @(negedge clk);
        end
        check("narrow we/busy", 32'(n_we), 32'd0);

        // Abort in cycle 20 of a replicate job, then restart two cycles later
        @(negedge clk);
        mode = 2'd0; shift = 2'd1; start = 1'b1; cyc = 1; n_done = 0;
        while (cyc < 20) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) n_done++;
        end
        check("abort busy before", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        if (done) n_done++;
        check("abort busy", 32'(busy), 32'd0);
        check("abort we", 32'(dst_we), 32'd0);
        check("abort done", 32'(n_done), 32'd0);
        run_job(0, 0, "restart after abort");

        // Abort together with start in IDLE suppresses the start
        @(negedge clk);
        mode = 2'd3; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort+start busy", 32'(busy), 32'd0);
        check("abort+start err", 32'(err), 32'd0);

        // Asynchronous reset in the ACCUM cycle of pixel 3 of a replicate x2 job
        @(negedge clk);
        mode = 2'd0; shift = 2'd1; start = 1'b1; cyc = 1;
        while (cyc < 12) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check("pre-reset busy", 32'(busy), 32'd1);
        check("pre-reset dst_data", 32'(dst_data), 32'd1);
        check("pre-reset dst_addr", 32'(dst_addr), 32'd70);
        #1 reset = 1'b1;
        #1 check_idle_outputs("async reset");
        @(negedge clk);
        reset = 1'b0;

        run_job(3, 3, "pass shift3");

        for (int j = 0; j < 14; j++) begin
            for (int i = 0; i < 16; i++) rom[i] = PW'($urandom_range(0, 255));
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
